mem_access_ctrl: RTL

- Load/store sequencer between the execute stage and the data-memory bus of the RV32I core.
- Takes the memory-control fields produced by the control unit (mem_read, mem_write, mem_width, mem_zero_extend), plus the ALU-computed address and the rs2 store data.
- Drives a single-outstanding request/ready bus: aligns addresses, generates byte strobes, and extracts and extends load data.
- Stalls the pipeline until the access completes and raises misalignment, illegal-width and timeout exceptions.

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between execute stage and the data-memory bus.
// Single outstanding request; aligns, strobes, extends load data, raises exceptions.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [31:0] bus_wdata_out,
    output logic [3:0]  bus_wstrb_out,
    input  logic        bus_ready_in,
    input  logic [31:0] bus_rdata_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic        exc_out,
    output logic [1:0]  exc_cause_out
);

    localparam logic [3:0] WidthWord = 4'b0000;
    localparam logic [3:0] WidthHalf = 4'b0101;
    localparam logic [3:0] WidthByte = 4'b1010;

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StErr} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       addr_lo_q;
    logic [3:0]       width_q;
    logic             zext_q;

    logic             req;
    logic             is_word, is_half, is_byte;
    logic             width_ok, misaligned;
    logic [3:0]       st_strb;
    logic [31:0]      st_data;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;
    logic [CNT_W-1:0] cnt_inc;
    logic             timeout_hit;

    always_comb begin
        req        = valid_in & (mem_read_in | mem_write_in);
        is_word    = (mem_width_in == WidthWord);
        is_half    = (mem_width_in == WidthHalf);
        is_byte    = (mem_width_in == WidthByte);
        width_ok   = is_word | is_half | is_byte;
        misaligned = (is_half & addr_in[0]) | (is_word & (addr_in[1:0] != 2'b00));
    end

    // Store lanes are replicated so the bus can pick any strobed byte.
    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata_in;
        if (is_byte) begin
            st_strb = 4'b0001 << addr_in[1:0];
            st_data = {4{wdata_in[7:0]}};
        end else if (is_half) begin
            st_strb = addr_in[1] ? 4'b1100 : 4'b0011;
            st_data = {2{wdata_in[15:0]}};
        end
    end

    always_comb begin
        unique case (addr_lo_q)
            2'd0:    ld_byte = bus_rdata_in[7:0];
            2'd1:    ld_byte = bus_rdata_in[15:8];
            2'd2:    ld_byte = bus_rdata_in[23:16];
            default: ld_byte = bus_rdata_in[31:24];
        endcase
        ld_half = addr_lo_q[1] ? bus_rdata_in[31:16] : bus_rdata_in[15:0];
        ld_data = bus_rdata_in;
        if (width_q == WidthByte) begin
            ld_data = zext_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (width_q == WidthHalf) begin
            ld_data = zext_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    // Compare the post-increment count so the request stays up exactly TIMEOUT_CYCLES cycles.
    always_comb begin
        cnt_inc     = cnt_q + CNT_W'(1);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
        stall_out   = ((state_q == StIdle) && req) || (state_q == StBusy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            addr_lo_q     <= '0;
            width_q       <= '0;
            zext_q        <= 1'b0;
            bus_req_out   <= 1'b0;
            bus_we_out    <= 1'b0;
            bus_addr_out  <= '0;
            bus_wdata_out <= '0;
            bus_wstrb_out <= '0;
            done_out      <= 1'b0;
            rdata_out     <= '0;
            exc_out       <= 1'b0;
            exc_cause_out <= '0;
        end else begin
            done_out <= 1'b0;
            exc_out  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        if ((mem_read_in & mem_write_in) | !width_ok) begin
                            exc_out       <= 1'b1;
                            exc_cause_out <= 2'b00;
                            state_q       <= StErr;
                        end else if (misaligned) begin
                            exc_out       <= 1'b1;
                            exc_cause_out <= mem_write_in ? 2'b10 : 2'b01;
                            state_q       <= StErr;
                        end else begin
                            addr_lo_q     <= addr_in[1:0];
                            width_q       <= mem_width_in;
                            zext_q        <= mem_zero_extend_in;
                            bus_req_out   <= 1'b1;
                            bus_we_out    <= mem_write_in;
                            bus_addr_out  <= {addr_in[31:2], 2'b00};
                            bus_wdata_out <= st_data;
                            bus_wstrb_out <= mem_write_in ? st_strb : 4'b0000;
                            cnt_q         <= '0;
                            state_q       <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (bus_ready_in) begin
                        if (!bus_we_out) begin
                            rdata_out <= ld_data;
                        end
                        done_out    <= 1'b1;
                        bus_req_out <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= StDone;
                    end else if (timeout_hit) begin
                        exc_out       <= 1'b1;
                        exc_cause_out <= 2'b11;
                        bus_req_out   <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= StErr;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
